// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end with a 2-entry {pc, instr} buffer.
// Issues one in-order instruction-memory request at a time and buffers the
// responses. A redirect flushes the buffer and restarts fetch at a new PC.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   imem_req/addr/gnt   fetch request handshake (addr word aligned)
//   imem_rvalid/rdata   in-order read response
//   stall               decode stall, holds the presented instruction
//   redirect/_pc        flush and restart fetch at redirect_pc (low bits ignored)
//   instr/instr_valid   buffer head presented to decode (NOP_INSTR when empty)
//   pc_out              PC of the presented instruction (0 when empty)
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc_out
);

  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 2;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

  state_t             state;
  logic [31:0]        fetch_pc;
  logic [31:0]        req_pc;
  logic [31:0]        fifo_pc    [DEPTH];
  logic [31:0]        fifo_instr [DEPTH];
  logic               rd_ptr;
  logic               wr_ptr;
  logic [CNT_W-1:0]   count;

  logic               grant;
  logic               push;
  logic               pop;
  logic [31:0]        redirect_aligned;
  logic               unused_redirect_lsbs;

  assign redirect_aligned     = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // In REQ nothing is outstanding, so the credit check reduces to buffer space.
  assign imem_req  = (state == REQ) && (count != CNT_W'(DEPTH));
  assign imem_addr = fetch_pc;
  assign grant     = imem_req && imem_gnt;

  // Responses are only accepted in WAIT; a redirect in the same cycle drops it.
  assign push = (state == WAIT) && imem_rvalid && !redirect;
  assign pop  = (count != '0) && !stall;

  assign instr_valid = (count != '0);
  assign instr       = instr_valid ? fifo_instr[rd_ptr] : NOP_INSTR;
  assign pc_out      = instr_valid ? fifo_pc[rd_ptr]    : 32'h0000_0000;

  // Fetch FSM and fetch PC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
    end else begin
      case (state)
        IDLE: state <= REQ;
        REQ: begin
          // A grant in the redirect cycle still leaves a response in flight.
          if (grant) state <= redirect ? DROP : WAIT;
        end
        WAIT: begin
          if (redirect)         state <= imem_rvalid ? REQ : DROP;
          else if (imem_rvalid) state <= REQ;
        end
        DROP: begin
          if (imem_rvalid) state <= REQ;
        end
        default: state <= IDLE;
      endcase

      if (grant) req_pc <= fetch_pc;

      if (redirect)   fetch_pc <= redirect_aligned;
      else if (grant) fetch_pc <= fetch_pc + 32'd4;
    end
  end

  // Buffer pointers and occupancy; redirect flushes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= '0;
    end else if (redirect) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Buffer storage; contents are don't-care while the entry is not valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]    <= req_pc;
      fifo_instr[wr_ptr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc_out;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc_out      (pc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs are driven and outputs sampled on the falling edge.
  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    cyc(); cyc();
    check("rst_req",   32'(imem_req),    32'd0);
    check("rst_addr",  imem_addr,        32'h0);
    check("rst_instr", instr,            NOP);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_pc",    pc_out,           32'h0);

    // Basic fetch: immediate grant, response one cycle later.
    rst = 1'b0;
    cyc();
    check("first_req",  32'(imem_req), 32'd1);
    check("first_addr", imem_addr,      32'h0);
    imem_gnt = 1'b1;
    cyc();
    imem_gnt = 1'b0;
    check("wait_noreq", 32'(imem_req), 32'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
    cyc();
    imem_rvalid = 1'b0;
    check("f0_valid", 32'(instr_valid), 32'd1);
    check("f0_instr", instr,            32'h0050_0093);
    check("f0_pc",    pc_out,           32'h0);
    check("f0_next",  imem_addr,        32'h4);
    cyc();
    check("pop_valid", 32'(instr_valid), 32'd0);
    check("pop_instr", instr,            NOP);
    check("pop_pc",    pc_out,           32'h0);

    // Grant withheld: request and address hold, no PC advance.
    for (int i = 0; i < 5; i++) begin
      check("nognt_req",  32'(imem_req), 32'd1);
      check("nognt_addr", imem_addr,     32'h4);
      cyc();
    end

    // Restart at 0, then fill the buffer under stall.
    redirect = 1'b1; redirect_pc = 32'h0;
    cyc();
    redirect = 1'b0;
    check("rd0_addr", imem_addr, 32'h0);
    stall = 1'b1; imem_gnt = 1'b1;
    cyc();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hAAAA_0001;
    cyc();
    imem_rvalid = 1'b0;
    check("s1_instr", instr,          32'hAAAA_0001);
    check("s1_req",   32'(imem_req),  32'd1);
    check("s1_addr",  imem_addr,      32'h4);
    imem_gnt = 1'b1;
    cyc();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hBBBB_0002;
    cyc();
    imem_rvalid = 1'b0;
    check("full_req",   32'(imem_req), 32'd0);
    check("full_instr", instr,         32'hAAAA_0001);
    check("full_pc",    pc_out,        32'h0);
    // Third response offered while full and in REQ: ignored, no grant taken.
    imem_rvalid = 1'b1; imem_rdata = 32'hCCCC_0003; imem_gnt = 1'b1;
    cyc();
    check("full3_req",   32'(imem_req), 32'd0);
    check("full3_addr",  imem_addr,     32'h8);
    check("full3_instr", instr,         32'hAAAA_0001);
    cyc();
    check("full4_instr", instr,         32'hAAAA_0001);
    check("full4_pc",    pc_out,        32'h0);
    imem_rvalid = 1'b0; imem_gnt = 1'b0; stall = 1'b0;
    cyc();
    check("drain_instr", instr,            32'hBBBB_0002);
    check("drain_pc",    pc_out,           32'h4);
    check("drain_valid", 32'(instr_valid), 32'd1);
    check("drain_req",   32'(imem_req),    32'd1);
    cyc();
    check("drain_empty", 32'(instr_valid), 32'd0);

    // Redirect while WAIT with a buffered entry: flush, DROP, discard one response.
    imem_gnt = 1'b1;
    cyc();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678;
    cyc();
    imem_rvalid = 1'b0; stall = 1'b1;
    check("x_instr", instr,  32'h1234_5678);
    check("x_pc",    pc_out, 32'h8);
    imem_gnt = 1'b1;
    cyc();
    imem_gnt = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0103;
    cyc();
    redirect = 1'b0;
    check("flush_valid", 32'(instr_valid), 32'd0);
    check("flush_instr", instr,            NOP);
    check("drop_req",    32'(imem_req),    32'd0);
    cyc();
    check("drop_req2",   32'(imem_req),    32'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    cyc();
    imem_rvalid = 1'b0;
    check("dropped_valid", 32'(instr_valid), 32'd0);
    check("redir_req",     32'(imem_req),    32'd1);
    check("redir_addr",    imem_addr,        32'h0000_0100);

    // PC wrap at the top of the address space.
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    cyc();
    redirect = 1'b0;
    check("top_addr", imem_addr, 32'hFFFF_FFFC);
    imem_gnt = 1'b1;
    cyc();
    imem_gnt = 1'b0;
    check("wrap_addr", imem_addr, 32'h0);
    imem_rvalid = 1'b1; imem_rdata = 32'h0FED_CBA9;
    cyc();
    imem_rvalid = 1'b0;
    check("wrap_instr", instr,  32'h0FED_CBA9);
    check("wrap_pc",    pc_out, 32'hFFFF_FFFC);

    // Asynchronous reset during WAIT, stale response after release.
    imem_gnt = 1'b1;
    cyc();
    imem_gnt = 1'b0;
    check("pre_rst_addr", imem_addr, 32'h4);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 32'(instr_valid), 32'd0);
    check("arst_addr",  imem_addr,        32'h0);
    check("arst_instr", instr,            NOP);
    check("arst_pc",    pc_out,           32'h0);
    check("arst_req",   32'(imem_req),    32'd0);
    cyc();
    rst = 1'b0; stall = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h5555_AAAA;
    cyc();
    check("stale_valid", 32'(instr_valid), 32'd0);
    check("stale_req",   32'(imem_req),    32'd1);
    check("stale_addr",  imem_addr,        32'h0);
    cyc();
    check("stale_valid2", 32'(instr_valid), 32'd0);
    imem_rvalid = 1'b0; imem_gnt = 1'b1;
    cyc();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h7777_0001;
    cyc();
    imem_rvalid = 1'b0;
    check("post_instr", instr,            32'h7777_0001);
    check("post_pc",    pc_out,           32'h0);
    check("post_valid", 32'(instr_valid), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
